coeff_token_decoder: RTL and testbench
======================================

Name: coeff_token_decoder

Overview:
- Parametrised successor to the team's single-channel value decoder.
- Converts Huffman-stage tokens (magnitude bits, size category, run) into signed coefficients tagged with zigzag position and component.
- Supports per-component DC prediction, restart-interval predictor clearing, ZRL/EOB tokens, sticky overrun error, and ready/valid back-pressure.
- Sits between the Huffman symbol decoder and the dequantiser/zigzag buffer.

Parameters:
- COEFF_WIDTH, 12, signed width of coefficient output and DC predictors.
- MAX_SIZE, 11, maximum size category accepted; value_in width.
- NUM_COMPONENTS, 3, number of independent DC predictors.
- DELTA_DECODE, 1, 1 = DC tokens are differences added to the component predictor; 0 = DC passed through undifferenced.

Ports:
- clk_in  input  1  clock.
- rst_in  input  1  asynchronous active-high reset.
- restart_in  input  1  restart marker pulse: clears predictors, position and error.
- value_in  input  MAX_SIZE  raw magnitude bits, LSB-aligned.
- size_in  input  $clog2(MAX_SIZE+1)  size category.
- run_in  input  4  zero run preceding this coefficient.
- dc_in  input  1  token is the DC term of a new block.
- comp_in  input  $clog2(NUM_COMPONENTS)  component index.
- valid_in  input  1  token valid.
- ready_out  output  1  token accepted when valid_in && ready_out.
- value_out  output  COEFF_WIDTH  signed coefficient.
- pos_out  output  6  zigzag index 0..63.
- comp_out  output  $clog2(NUM_COMPONENTS)  component of value_out.
- eob_out  output  1  token is end-of-block (value_out = 0).
- err_out  output  1  sticky position overrun.
- valid_out  output  1  output valid.
- ready_in  input  1  downstream ready.

Behaviour:
- Reset (async, rst_in high): valid_out=0, value_out=0, pos_out=0, comp_out=0, eob_out=0, err_out=0, all predictors=0, position counter=0.
- Handshake: ready_out = ~valid_out | ready_in. Outputs are registered; latency is 1 cycle from acceptance. While valid_out && ~ready_in, all outputs hold stable.
- Magnitude extension:
  - size 0 gives 0.
  - If value_in[size-1]=1, result = value_in zero-extended.
  - Otherwise result = value_in - (2^size - 1).
  - Computed at COEFF_WIDTH+1 bits.
- DC token:
  - With DELTA_DECODE=1: sum = predictor[comp_in] + extended. The sum saturates to the COEFF_WIDTH signed range, is emitted, and is written back to predictor[comp_in].
  - With DELTA_DECODE=0: extended value is emitted; predictor is unused.
  - pos_out=0; counter becomes 1.
- AC token (dc_in=0):
  - size>0: pos_out = counter + run_in; counter becomes counter + run_in + 1.
  - size=0, run=15 (ZRL): emits value 0 at counter+15; counter += 16.
  - size=0, run=0 (EOB): emits value 0, eob_out=1, pos_out=counter; counter becomes 0.
  - size=0 with any other run: treated as EOB.
- Overrun: if an AC target position exceeds 63, err_out sets and stays set until restart_in or reset. The token is still emitted with pos_out=63, and the counter saturates at 64.
- size_in > MAX_SIZE: sets err_out; value_out=0.
- restart_in:
  - Clears predictors, counter and err_out on the next edge.
  - If a token is accepted in the same cycle, restart is applied first; the token then uses predictor 0 and counter 0.
  - restart_in does not drop a pending output.
- Components have separate predictors but share one position counter (blocks are interleaved whole).
- Reset mid-stream discards any pending output immediately (valid_out drops asynchronously).

Test Plan:
- DC diff tokens for comp 0: (size 2, value 2'b01), then (size 3, value 3'b101) → value_out -2 then +3 (predictor -2+5); pos_out 0 for both.
- Interleaved DC for comp 0 then comp 1, each diff +4 (size 3, value 3'b100) → outputs 4 and 4. A second comp-0 DC of +4 → 8.
- Block sequence DC, AC run 2 size 1 value 1, ZRL, AC run 0 size 1 value 0, EOB → pos_out 0, 3, 19, 20, 21(eob_out=1); values x, 1, 0, -1, 0.
- Hold ready_in low for 3 cycles with valid_in high → ready_out=0, outputs stable; release → next token appears 1 cycle after acceptance, none lost or duplicated.
- AC run 15 size 1 issued at counter 60 → err_out=1 and pos_out=63. Then restart_in → err_out=0, and the next DC +1 outputs 1.
- Saturation: predictor 2040 plus diff +100 → value_out 2047. Assert rst_in mid-burst → valid_out=0 immediately and predictors are 0 after release.

Source files
------------

// File: rtl/coeff_token_decoder.sv
// -----------------------------------------------------------------------------
// coeff_token_decoder
//
// Turns Huffman-stage tokens (raw magnitude bits, size category, zero run,
// DC flag, component) into signed coefficients tagged with their zigzag
// position and component. It sits between the Huffman symbol decoder and the
// dequantiser / zigzag buffer.
//
// Features: per-component DC prediction (optional), restart-marker clearing,
// ZRL and EOB tokens, a sticky overrun / bad-size error flag, and a one-deep
// registered output stage with ready/valid back-pressure.
//
// Ports
//   clk_in      in   clock
//   rst_in      in   asynchronous active-high reset
//   restart_in  in   restart marker: clears predictors, position and error
//   value_in    in   [MAX_SIZE]        raw magnitude bits, LSB-aligned
//   size_in     in   [SIZE_W]          size category
//   run_in      in   [4]               zero run preceding this coefficient
//   dc_in       in   token is the DC term of a new block
//   comp_in     in   [COMP_W]          component index
//   valid_in    in   token valid
//   ready_out   out  token accepted when valid_in && ready_out
//   value_out   out  [COEFF_WIDTH]     signed coefficient
//   pos_out     out  [6]               zigzag index 0..63
//   comp_out    out  [COMP_W]          component of value_out
//   eob_out     out  token is end-of-block (value_out = 0)
//   err_out     out  sticky error (position overrun or size out of range)
//   valid_out   out  output valid
//   ready_in    in   downstream ready
// -----------------------------------------------------------------------------
module coeff_token_decoder #(
    parameter int COEFF_WIDTH    = 12,
    parameter int MAX_SIZE       = 11,
    parameter int NUM_COMPONENTS = 3,
    parameter int DELTA_DECODE   = 1,
    localparam int SIZE_W = $clog2(MAX_SIZE + 1),
    localparam int COMP_W = (NUM_COMPONENTS > 1) ? $clog2(NUM_COMPONENTS) : 1
) (
    input  logic                          clk_in,
    input  logic                          rst_in,
    input  logic                          restart_in,
    input  logic [MAX_SIZE-1:0]           value_in,
    input  logic [SIZE_W-1:0]             size_in,
    input  logic [3:0]                    run_in,
    input  logic                          dc_in,
    input  logic [COMP_W-1:0]             comp_in,
    input  logic                          valid_in,
    output logic                          ready_out,
    output logic signed [COEFF_WIDTH-1:0] value_out,
    output logic [5:0]                    pos_out,
    output logic [COMP_W-1:0]             comp_out,
    output logic                          eob_out,
    output logic                          err_out,
    output logic                          valid_out,
    input  logic                          ready_in
);

    // The extension is done one bit wider than the coefficient, and the DC
    // sum two bits wider, so neither can wrap before saturation.
    // MAX_SIZE must stay below COEFF_WIDTH + 1.
    localparam int EXT_W = COEFF_WIDTH + 1;
    localparam int SUM_W = COEFF_WIDTH + 2;

    localparam logic [SIZE_W-1:0] MAX_SIZE_V = SIZE_W'(MAX_SIZE);

    localparam logic signed [SUM_W-1:0] SAT_MAX =
        {{(SUM_W - COEFF_WIDTH + 1){1'b0}}, {(COEFF_WIDTH - 1){1'b1}}};
    localparam logic signed [SUM_W-1:0] SAT_MIN =
        {{(SUM_W - COEFF_WIDTH + 1){1'b1}}, {(COEFF_WIDTH - 1){1'b0}}};

    // Huffman magnitude extension. A clear top bit means a negative value,
    // encoded as the one's complement of the magnitude.
    function automatic logic signed [EXT_W-1:0] extend_mag(
        input logic [MAX_SIZE-1:0] bits,
        input logic [SIZE_W-1:0]   size
    );
        logic [EXT_W-1:0] mask;
        logic [EXT_W-1:0] raw;
        logic [EXT_W-1:0] msb;
        mask = (EXT_W'(1) << size) - EXT_W'(1);
        raw  = {{(EXT_W - MAX_SIZE){1'b0}}, bits} & mask;
        // mask >> 1 covers bits below size-1, so this isolates bit size-1.
        msb  = raw & ~(mask >> 1);
        if (size == '0) begin
            extend_mag = '0;
        end else if (msb != '0) begin
            extend_mag = raw;
        end else begin
            extend_mag = raw - mask;
        end
    endfunction

    // Sign-extend a magnitude-extension result to the sum width.
    function automatic logic signed [SUM_W-1:0] widen_ext(
        input logic signed [EXT_W-1:0] x
    );
        widen_ext = {{(SUM_W - EXT_W){x[EXT_W-1]}}, x};
    endfunction

    // Sign-extend a coefficient-width value to the sum width.
    function automatic logic signed [SUM_W-1:0] widen_coef(
        input logic signed [COEFF_WIDTH-1:0] x
    );
        widen_coef = {{(SUM_W - COEFF_WIDTH){x[COEFF_WIDTH-1]}}, x};
    endfunction

    // Clamp to the signed coefficient range.
    function automatic logic signed [COEFF_WIDTH-1:0] saturate(
        input logic signed [SUM_W-1:0] x
    );
        if (x > SAT_MAX) begin
            saturate = SAT_MAX[COEFF_WIDTH-1:0];
        end else if (x < SAT_MIN) begin
            saturate = SAT_MIN[COEFF_WIDTH-1:0];
        end else begin
            saturate = x[COEFF_WIDTH-1:0];
        end
    endfunction

    // Registered state
    logic                          valid_q, valid_d;
    logic signed [COEFF_WIDTH-1:0] value_q, value_d;
    logic [5:0]                    pos_q,   pos_d;
    logic [COMP_W-1:0]             comp_q,  comp_d;
    logic                          eob_q,   eob_d;
    logic                          err_q,   err_d;
    logic [6:0]                    cnt_q,   cnt_d;   // saturates at 64
    logic signed [COEFF_WIDTH-1:0] pred_q [NUM_COMPONENTS];
    logic signed [COEFF_WIDTH-1:0] pred_d [NUM_COMPONENTS];

    // Token decode
    logic                          accept;
    logic                          size_bad;
    logic                          size_zero;
    logic                          is_eob;
    logic signed [EXT_W-1:0]       ext_val;
    logic signed [COEFF_WIDTH-1:0] pred_sel;
    logic signed [COEFF_WIDTH-1:0] dc_sum;
    logic [6:0]                    base_cnt;
    logic                          base_err;
    logic [7:0]                    target;
    logic                          overrun;
    logic                          pred_wr;

    logic signed [COEFF_WIDTH-1:0] tok_value;
    logic [5:0]                    tok_pos;
    logic [6:0]                    tok_cnt;
    logic                          tok_eob;
    logic                          tok_overrun;

    assign ready_out = ~valid_q | ready_in;
    assign accept    = valid_in & ready_out;

    assign value_out = value_q;
    assign pos_out   = pos_q;
    assign comp_out  = comp_q;
    assign eob_out   = eob_q;
    assign err_out   = err_q;
    assign valid_out = valid_q;

    // Decode the incoming token against the state it will see, i.e. with a
    // same-cycle restart already applied.
    always_comb begin
        size_bad  = (size_in > MAX_SIZE_V);
        size_zero = (size_in == '0);
        is_eob    = size_zero && (run_in != 4'd15);
        ext_val   = size_bad ? '0 : extend_mag(value_in, size_in);
        base_cnt  = restart_in ? 7'd0 : cnt_q;
        base_err  = restart_in ? 1'b0 : err_q;
        pred_sel  = '0;
        for (int i = 0; i < NUM_COMPONENTS; i++) begin
            pred_sel = ((comp_in == COMP_W'(i)) && !restart_in) ? pred_q[i] : pred_sel;
        end
        dc_sum  = saturate(widen_coef(pred_sel) + widen_ext(ext_val));
        // ZRL and plain AC share the rule: target = counter + run.
        target  = {1'b0, base_cnt} + {4'd0, run_in};
        overrun = (target > 8'd63);
    end

    // Per-token result: coefficient, position and next counter value.
    always_comb begin
        tok_value   = '0;
        tok_pos     = 6'd0;
        tok_cnt     = base_cnt;
        tok_eob     = 1'b0;
        tok_overrun = 1'b0;
        if (dc_in) begin
            if (size_bad) begin
                tok_value = '0;
            end else if (DELTA_DECODE != 0) begin
                tok_value = dc_sum;
            end else begin
                tok_value = saturate(widen_ext(ext_val));
            end
            tok_pos = 6'd0;
            tok_cnt = 7'd1;
        end else if (is_eob) begin
            tok_value = '0;
            tok_pos   = base_cnt[6] ? 6'd63 : base_cnt[5:0];
            tok_cnt   = 7'd0;
            tok_eob   = 1'b1;
        end else begin
            // ext_val is zero for ZRL and for an out-of-range size.
            tok_value   = saturate(widen_ext(ext_val));
            tok_pos     = overrun ? 6'd63 : target[5:0];
            tok_cnt     = overrun ? 7'd64 : (target[6:0] + 7'd1);
            tok_overrun = overrun;
        end
    end

    // Next-state: restart first, then token acceptance, then output drain.
    always_comb begin
        valid_d = valid_q;
        value_d = value_q;
        pos_d   = pos_q;
        comp_d  = comp_q;
        eob_d   = eob_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        pred_d  = pred_q;
        pred_wr = dc_in && (DELTA_DECODE != 0) && !size_bad;

        if (restart_in) begin
            cnt_d = 7'd0;
            err_d = 1'b0;
            for (int i = 0; i < NUM_COMPONENTS; i++) begin
                pred_d[i] = '0;
            end
        end else begin
            cnt_d = cnt_q;
        end

        if (accept) begin
            valid_d = 1'b1;
            value_d = tok_value;
            pos_d   = tok_pos;
            comp_d  = comp_in;
            eob_d   = tok_eob;
            cnt_d   = tok_cnt;
            err_d   = base_err | tok_overrun | size_bad;
            for (int i = 0; i < NUM_COMPONENTS; i++) begin
                pred_d[i] = (pred_wr && (comp_in == COMP_W'(i))) ? dc_sum : pred_d[i];
            end
        end else if (ready_in) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            valid_q <= 1'b0;
            value_q <= '0;
            pos_q   <= 6'd0;
            comp_q  <= '0;
            eob_q   <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= 7'd0;
            for (int i = 0; i < NUM_COMPONENTS; i++) begin
                pred_q[i] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            value_q <= value_d;
            pos_q   <= pos_d;
            comp_q  <= comp_d;
            eob_q   <= eob_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
            for (int i = 0; i < NUM_COMPONENTS; i++) begin
                pred_q[i] <= pred_d[i];
            end
        end
    end

endmodule

// File: tb/tb_coeff_token_decoder.sv
// Directed bench for coeff_token_decoder with a behavioural reference model.
module tb_coeff_token_decoder;

    localparam int CW = 12;
    localparam int MS = 11;
    localparam int NC = 3;

    logic               clk = 1'b0;
    logic               rst_in;
    logic               restart_in;
    logic [10:0]        value_in;
    logic [3:0]         size_in;
    logic [3:0]         run_in;
    logic               dc_in;
    logic [1:0]         comp_in;
    logic               valid_in;
    logic               ready_out;
    logic signed [11:0] value_out;
    logic [5:0]         pos_out;
    logic [1:0]         comp_out;
    logic               eob_out;
    logic               err_out;
    logic               valid_out;
    logic               ready_in;

    always #5 clk = ~clk;

    coeff_token_decoder #(
        .COEFF_WIDTH(CW), .MAX_SIZE(MS), .NUM_COMPONENTS(NC), .DELTA_DECODE(1)
    ) dut (
        .clk_in(clk), .rst_in(rst_in), .restart_in(restart_in),
        .value_in(value_in), .size_in(size_in), .run_in(run_in),
        .dc_in(dc_in), .comp_in(comp_in), .valid_in(valid_in),
        .ready_out(ready_out), .value_out(value_out), .pos_out(pos_out),
        .comp_out(comp_out), .eob_out(eob_out), .err_out(err_out),
        .valid_out(valid_out), .ready_in(ready_in)
    );

    typedef struct {
        int value;
        int pos;
        int comp;
        bit eob;
        bit err;
    } exp_t;

    exp_t expq[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   pops_total  = 0;
    int   sent_total  = 0;
    int   last_val, last_pos, last_comp;
    bit   last_eob, last_err;

    // reference model state
    int   pred_m[NC];
    int   cnt_m;
    bit   err_m;
    bit   held;
    int   snap_val, snap_pos, snap_comp;
    bit   snap_eob;
    exp_t e_pop, e_new;
    int   sz, ex, tgt, s;
    bit   bad;

    task automatic chk(input string name, input int act, input int req);
        vectors++;
        if (act != req) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic int ext_of(input int size, input int bits);
        int mask;
        int v;
        if (size == 0) return 0;
        mask = (1 << size) - 1;
        v = bits & mask;
        if (v >= (1 << (size - 1))) return v;
        return v - mask;
    endfunction

    function automatic int clamp(input int x);
        if (x > 2047) return 2047;
        if (x < -2048) return -2048;
        return x;
    endfunction

    // Single compare process: checks transfers and holds, then advances model.
    always @(negedge clk) begin
        if (rst_in) begin
            expq.delete();
            held  = 1'b0;
            cnt_m = 0;
            err_m = 1'b0;
            for (int i = 0; i < NC; i++) pred_m[i] = 0;
        end else begin
            chk("ready_rule", int'(ready_out), int'(!valid_out || ready_in));
            if (held) begin
                chk("hold_valid", int'(valid_out), 1);
                chk("hold_value", value_out, snap_val);
                chk("hold_pos", int'(pos_out), snap_pos);
                chk("hold_comp", int'(comp_out), snap_comp);
                chk("hold_eob", int'(eob_out), int'(snap_eob));
            end
            if (valid_out && ready_in) begin
                if (expq.size() == 0) begin
                    chk("expected_queue_depth", expq.size(), 1);
                end else begin
                    e_pop = expq.pop_front();
                    chk("out_value", value_out, e_pop.value);
                    chk("out_pos", int'(pos_out), e_pop.pos);
                    chk("out_comp", int'(comp_out), e_pop.comp);
                    chk("out_eob", int'(eob_out), int'(e_pop.eob));
                    chk("out_err", int'(err_out), int'(e_pop.err));
                    pops_total++;
                    last_val  = value_out;
                    last_pos  = pos_out;
                    last_comp = comp_out;
                    last_eob  = eob_out;
                    last_err  = err_out;
                end
            end
            held      = valid_out && !ready_in;
            snap_val  = value_out;
            snap_pos  = pos_out;
            snap_comp = comp_out;
            snap_eob  = eob_out;

            if (restart_in) begin
                for (int i = 0; i < NC; i++) pred_m[i] = 0;
                cnt_m = 0;
                err_m = 1'b0;
            end
            if (valid_in && ready_out) begin
                e_new.comp = comp_in;
                e_new.eob  = 1'b0;
                sz  = size_in;
                bad = (sz > MS);
                ex  = bad ? 0 : ext_of(sz, int'(value_in));
                if (bad) err_m = 1'b1;
                if (dc_in) begin
                    if (bad) begin
                        e_new.value = 0;
                    end else begin
                        s = clamp(pred_m[comp_in] + ex);
                        pred_m[comp_in] = s;
                        e_new.value = s;
                    end
                    e_new.pos = 0;
                    cnt_m = 1;
                end else if (sz == 0 && run_in != 4'd15) begin
                    e_new.value = 0;
                    e_new.eob   = 1'b1;
                    e_new.pos   = (cnt_m > 63) ? 63 : cnt_m;
                    cnt_m = 0;
                end else begin
                    tgt = cnt_m + int'(run_in);
                    e_new.value = ex;
                    if (tgt > 63) begin
                        err_m = 1'b1;
                        e_new.pos = 63;
                        cnt_m = 64;
                    end else begin
                        e_new.pos = tgt;
                        cnt_m = tgt + 1;
                    end
                end
                e_new.err = err_m;
                expq.push_back(e_new);
            end
        end
    end

    // Present one token just after a clock edge and hold it until accepted.
    task automatic send(input bit dc, input int comp, input int size,
                        input int val, input int run, input bit rs);
        int waited = 0;
        bit ok = 1'b0;
        @(posedge clk);
        #1;
        dc_in      = dc;
        comp_in    = 2'(comp);
        size_in    = 4'(size);
        value_in   = 11'(val);
        run_in     = 4'(run);
        restart_in = rs;
        valid_in   = 1'b1;
        while (!ok && waited < 50) begin
            @(negedge clk);
            if (ready_out) ok = 1'b1;
            else waited++;
        end
        chk("token_accepted", int'(ok), 1);
        @(posedge clk);
        #1;
        valid_in   = 1'b0;
        restart_in = 1'b0;
        sent_total++;
    endtask

    // Wait for all sent tokens to drain, then pin the last output to literals.
    task automatic expect_out(input string tag, input int v, input int p,
                              input int c, input bit eob, input bit err);
        int w = 0;
        while (pops_total < sent_total && w < 20) begin
            @(negedge clk);
            #1;
            w++;
        end
        chk({tag, "_drained"}, int'(pops_total >= sent_total), 1);
        chk({tag, "_value"}, last_val, v);
        chk({tag, "_pos"}, last_pos, p);
        chk({tag, "_comp"}, last_comp, c);
        chk({tag, "_eob"}, int'(last_eob), int'(eob));
        chk({tag, "_err"}, int'(last_err), int'(err));
    endtask

    task automatic do_restart();
        @(posedge clk);
        #1;
        restart_in = 1'b1;
        @(posedge clk);
        #1;
        restart_in = 1'b0;
        chk("restart_clears_err", int'(err_out), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_in = 1'b1; restart_in = 1'b0; value_in = '0; size_in = '0;
        run_in = '0; dc_in = 1'b0; comp_in = '0; valid_in = 1'b0; ready_in = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", int'(valid_out), 0);
        chk("rst_value", value_out, 0);
        chk("rst_pos", int'(pos_out), 0);
        chk("rst_comp", int'(comp_out), 0);
        chk("rst_eob", int'(eob_out), 0);
        chk("rst_err", int'(err_out), 0);
        chk("rst_ready", int'(ready_out), 1);
        rst_in = 1'b0;

        // DC differences on component 0
        send(1, 0, 2, 1, 0, 0);  expect_out("dc_neg", -2, 0, 0, 0, 0);
        send(1, 0, 3, 5, 0, 0);  expect_out("dc_pos", 3, 0, 0, 0, 0);
        // restart together with a token: predictor already cleared
        send(1, 0, 3, 4, 0, 1);  expect_out("dc_restart", 4, 0, 0, 0, 0);
        send(1, 1, 3, 4, 0, 0);  expect_out("dc_comp1", 4, 0, 1, 0, 0);
        send(1, 0, 3, 4, 0, 0);  expect_out("dc_comp0_again", 8, 0, 0, 0, 0);

        // one block: DC, AC, ZRL, AC, EOB
        send(1, 0, 1, 1, 0, 0);  expect_out("blk_dc", 9, 0, 0, 0, 0);
        send(0, 0, 1, 1, 2, 0);  expect_out("blk_ac1", 1, 3, 0, 0, 0);
        send(0, 0, 0, 0, 15, 0); expect_out("blk_zrl", 0, 19, 0, 0, 0);
        send(0, 0, 1, 0, 0, 0);  expect_out("blk_ac2", -1, 20, 0, 0, 0);
        send(0, 0, 0, 0, 0, 0);  expect_out("blk_eob", 0, 21, 0, 1, 0);

        // back-pressure: output held three cycles with a token waiting
        @(posedge clk);
        #1;
        ready_in = 1'b0;
        send(1, 2, 2, 2, 0, 0);
        fork
            begin
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk);
                    #1;
                    chk("hold_ready_out", int'(ready_out), 0);
                end
                @(posedge clk);
                #1;
                ready_in = 1'b1;
            end
            send(0, 2, 2, 1, 1, 0);
        join
        expect_out("hold_b", -2, 2, 2, 0, 0);

        // position overrun
        send(1, 0, 0, 0, 0, 0);  expect_out("ovr_dc", 9, 0, 0, 0, 0);
        send(0, 0, 0, 0, 15, 0);
        send(0, 0, 0, 0, 15, 0);
        send(0, 0, 0, 0, 15, 0); expect_out("ovr_zrl3", 0, 48, 0, 0, 0);
        send(0, 0, 1, 1, 10, 0); expect_out("ovr_pos59", 1, 59, 0, 0, 0);
        send(0, 0, 1, 1, 15, 0); expect_out("overrun", 1, 63, 0, 0, 1);
        send(0, 0, 1, 0, 0, 0);  expect_out("overrun_sat", -1, 63, 0, 0, 1);
        do_restart();
        send(1, 0, 1, 1, 0, 0);  expect_out("post_restart_dc", 1, 0, 0, 0, 0);

        // size out of range
        send(0, 0, 12, 5, 0, 0); expect_out("bad_size", 0, 1, 0, 0, 1);
        do_restart();

        // size 0 with an odd run behaves as EOB
        send(1, 1, 1, 0, 0, 0);  expect_out("dc_m1", -1, 0, 1, 0, 0);
        send(0, 1, 0, 0, 5, 0);  expect_out("eob_run5", 0, 1, 1, 1, 0);

        // saturation at both ends
        send(1, 2, 11, 2040, 0, 0); expect_out("sat_base", 2040, 0, 2, 0, 0);
        send(1, 2, 7, 100, 0, 0);   expect_out("sat_pos", 2047, 0, 2, 0, 0);
        send(1, 1, 11, 0, 0, 0);    expect_out("min_exact", -2048, 0, 1, 0, 0);
        send(1, 1, 11, 0, 0, 0);    expect_out("sat_neg", -2048, 0, 1, 0, 0);

        // reset with an output pending
        send(1, 2, 1, 1, 0, 0);
        #2;
        rst_in = 1'b1;
        #1;
        chk("midrst_valid", int'(valid_out), 0);
        chk("midrst_value", value_out, 0);
        @(posedge clk);
        #1;
        rst_in = 1'b0;
        sent_total = pops_total;
        send(1, 2, 1, 1, 0, 0);  expect_out("postrst_dc2", 1, 0, 2, 0, 0);
        send(1, 0, 1, 1, 0, 0);  expect_out("postrst_dc0", 1, 0, 0, 0, 0);

        repeat (3) @(posedge clk);
        #1;
        chk("queue_empty", expq.size(), 0);
        chk("all_delivered", pops_total, sent_total);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
